// File: rtl/key_decoder_if.sv
// Token bus from the keypad decoder to the downstream calculator logic.
// valid/ready: a token is transferred on a rising edge where tok_valid and tok_ready are both 1;
// once tok_valid rises, tok_type/tok_value stay stable until that edge, and tok_ready is ignored while tok_valid is 0.
interface key_decoder_if;
    logic       tok_valid;
    logic [1:0] tok_type;
    logic [7:0] tok_value;
    logic       tok_ready;

    modport master (
        output tok_valid,
        output tok_type,
        output tok_value,
        input  tok_ready
    );

    modport slave (
        input  tok_valid,
        input  tok_type,
        input  tok_value,
        output tok_ready
    );
endinterface

// File: rtl/key_decoder.sv
// Turns keypad key events into number/operator tokens: digits accumulate into an
// 8-bit entry, operators flush it as a number token followed by an operator token.
module key_decoder (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [3:0]           keycode,
    input  logic                 keystrobe,
    key_decoder_if.master        tok,
    output logic [7:0]           entry_value,
    output logic                 err_pulse,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENTRY    = 2'd1,
        EMIT_NUM = 2'd2,
        EMIT_OP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        strobe_q;
    logic        arm_q;
    logic [7:0]  entry_q, entry_d;
    logic [1:0]  op_q, op_d, op_sel;
    logic        err_q, err_d;
    logic        tok_valid_q, tok_valid_d;
    logic [1:0]  tok_type_q, tok_type_d;
    logic [7:0]  tok_value_q, tok_value_d;
    logic        key_event;
    logic        handshake;
    logic [11:0] digit_sum;

    // arm_q stays low until the key is seen released after reset, so a key
    // held through reset release cannot fire an event.
    assign key_event = keystrobe & ~strobe_q & arm_q;
    assign handshake = tok_valid_q & tok.tok_ready;
    assign digit_sum = ({4'b0, entry_q} * 12'd10) + {8'b0, keycode};

    always_comb begin
        op_sel = 2'b11;
        case (keycode)
            4'd10:   op_sel = 2'b01;
            4'd11:   op_sel = 2'b10;
            default: op_sel = 2'b11;
        endcase
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        op_d    = op_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE, ENTRY: begin
                if (key_event) begin
                    if (keycode <= 4'd9) begin
                        if (digit_sum > 12'd255) begin
                            err_d = 1'b1;
                        end else begin
                            entry_d = digit_sum[7:0];
                            state_d = ENTRY;
                        end
                    end else if (keycode == 4'd15) begin
                        entry_d = 8'd0;
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else if (keycode != 4'd13 && keycode != 4'd14) begin
                        op_d    = op_sel;
                        state_d = (state_q == ENTRY) ? EMIT_NUM : EMIT_OP;
                    end
                end
            end
            EMIT_NUM: begin
                err_d = key_event;
                if (handshake) begin
                    state_d = EMIT_OP;
                    entry_d = 8'd0;
                end
            end
            EMIT_OP: begin
                err_d = key_event;
                if (handshake) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Token outputs are registered from the next state so they line up with it.
    always_comb begin
        tok_valid_d = 1'b0;
        tok_type_d  = 2'b00;
        tok_value_d = 8'd0;
        case (state_d)
            EMIT_NUM: begin
                tok_valid_d = 1'b1;
                tok_value_d = entry_d;
            end
            EMIT_OP: begin
                tok_valid_d = 1'b1;
                tok_type_d  = op_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            strobe_q    <= 1'b0;
            arm_q       <= 1'b0;
            entry_q     <= 8'd0;
            op_q        <= 2'b00;
            err_q       <= 1'b0;
            tok_valid_q <= 1'b0;
            tok_type_q  <= 2'b00;
            tok_value_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            strobe_q    <= keystrobe;
            if (!keystrobe) arm_q <= 1'b1;
            entry_q     <= entry_d;
            op_q        <= op_d;
            err_q       <= err_d;
            tok_valid_q <= tok_valid_d;
            tok_type_q  <= tok_type_d;
            tok_value_q <= tok_value_d;
        end
    end

    assign tok.tok_valid = tok_valid_q;
    assign tok.tok_type  = tok_type_q;
    assign tok.tok_value = tok_value_q;
    assign entry_value   = entry_q;
    assign err_pulse     = err_q;
    assign state_dbg     = state_q;

endmodule
